// File: rtl/oisc8_pkg.sv
// Shared OISC8 types: instruction bus address maps, sequencer states and
// the fixed NOP/HALT encodings.
package oisc8_pkg;

  typedef enum logic [3:0] {
    DST_ACC0  = 4'h0,
    DST_ACC1  = 4'h1,
    DST_BRPT0 = 4'h2,
    DST_BRPT1 = 4'h3,
    DST_BRZ   = 4'h4,
    DST_REG0  = 4'h5
  } e_iaddr_dst;

  typedef enum logic [7:0] {
    SRC_NULL  = 8'h00,
    SRC_ACC0  = 8'h01,
    SRC_REG0R = 8'h10
  } e_iaddr_src;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    RUN,
    STALL,
    FLUSH,
    HALT
  } e_seq_state;

  // dst 15 is unmapped on the IBus, so nothing reacts to these words
  localparam logic [3:0]  DST_NONE   = 4'hF;
  localparam logic [12:0] NOP_INSTR  = {1'b0, DST_NONE, SRC_NULL};
  localparam logic [12:0] HALT_INSTR = {1'b1, DST_NONE, 8'hFF};

endpackage

// File: rtl/oisc8_seq_branch.sv
// Combinational decode of the issued word: BRZ taken, HALT, branch target.
module oisc8_seq_branch
  import oisc8_pkg::*;
#(
  parameter int unsigned PCWIDTH = 16,
  parameter int unsigned IWIDTH  = 13
) (
  input  logic [IWIDTH-1:0]  instr,
  input  logic [7:0]         bus_data,
  input  logic [PCWIDTH-1:0] brpt,
  output logic               br_taken,
  output logic               is_halt,
  output logic [PCWIDTH-1:0] br_target
);

  logic       imm;
  logic [3:0] dst;
  logic [7:0] src;
  logic [7:0] moved;

  always_comb begin
    imm       = instr[IWIDTH-1];
    dst       = instr[11:8];
    src       = instr[7:0];
    // immediate moves carry their value in the src field
    moved     = imm ? src : bus_data;
    br_taken  = (dst == DST_BRZ) && (moved == 8'h00);
    is_halt   = (instr == HALT_INSTR);
    br_target = brpt;
  end

endmodule

// File: rtl/oisc8_seq.sv
// OISC8 instruction sequencer: fetches from a 1-cycle synchronous ROM and
// issues one move per cycle, handling BRZ, stall skid and HALT.
module oisc8_seq
  import oisc8_pkg::*;
#(
  parameter int unsigned        PCWIDTH  = 16,
  parameter int unsigned        IWIDTH   = 13,
  parameter logic [PCWIDTH-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [PCWIDTH-1:0] pc_start,
  input  logic               stall,
  output logic [PCWIDTH-1:0] rom_addr,
  input  logic [IWIDTH-1:0]  rom_data,
  output logic [IWIDTH-1:0]  instr,
  input  logic [7:0]         bus_data,
  input  logic [PCWIDTH-1:0] brpt,
  output logic [PCWIDTH-1:0] pc,
  output logic               running,
  output logic               halted
);

  e_seq_state         state_q, state_d;
  logic [PCWIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [PCWIDTH-1:0] pc_q, pc_d;
  logic [IWIDTH-1:0]  skid_q, skid_d;
  logic               running_q, running_d;
  logic               halted_q, halted_d;
  logic               br_taken, is_halt;
  logic [PCWIDTH-1:0] br_target;

  // Issue mux: only RUN and a released STALL put a real word on the bus
  always_comb begin
    instr = NOP_INSTR;
    case (state_q)
      RUN:     if (!stall) instr = rom_data;
      STALL:   if (!stall) instr = skid_q;
      default: instr = NOP_INSTR;
    endcase
  end

  oisc8_seq_branch #(
    .PCWIDTH(PCWIDTH),
    .IWIDTH (IWIDTH)
  ) u_branch (
    .instr    (instr),
    .bus_data (bus_data),
    .brpt     (brpt),
    .br_taken (br_taken),
    .is_halt  (is_halt),
    .br_target(br_target)
  );

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    pc_d       = pc_q;
    skid_d     = skid_q;
    case (state_q)
      IDLE, HALT: begin
        if (start) begin
          rom_addr_d = pc_start;
          state_d    = PRIME;
        end
      end
      PRIME, FLUSH: begin
        pc_d       = rom_addr_q;
        rom_addr_d = rom_addr_q + PCWIDTH'(1);
        state_d    = RUN;
      end
      RUN, STALL: begin
        // Stalled words are not issued; the ROM output is parked in the skid
        // on entry and reissued (and decoded) once the stall drops.
        if (stall) begin
          if (state_q == RUN) skid_d = rom_data;
          state_d = STALL;
        end else if (is_halt) begin
          state_d = HALT;
        end else if (br_taken) begin
          rom_addr_d = br_target;
          state_d    = FLUSH;
        end else begin
          pc_d       = rom_addr_q;
          rom_addr_d = rom_addr_q + PCWIDTH'(1);
          state_d    = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
    running_d = (state_d == PRIME) || (state_d == RUN) ||
                (state_d == STALL) || (state_d == FLUSH);
    halted_d  = (state_d == HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rom_addr_q <= RESET_PC;
      pc_q       <= RESET_PC;
      skid_q     <= NOP_INSTR;
      running_q  <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      pc_q       <= pc_d;
      skid_q     <= skid_d;
      running_q  <= running_d;
      halted_q   <= halted_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign pc       = pc_q;
  assign running  = running_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_oisc8_seq.sv
// Self-checking bench for oisc8_seq: per-cycle vector table through a
// scoreboard queue, plus hand sequences for reset-in-stall and pc wrap.
module tb_oisc8_seq;

  localparam logic [12:0] NOP  = 13'h0F00;
  localparam logic [12:0] HLT  = 13'h1FFF;
  localparam logic [12:0] BRZI = {1'b1, 4'h4, 8'h00};
  localparam logic [12:0] BRZB = {1'b0, 4'h4, 8'h10};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic [15:0] pc_start = '0;
  logic [15:0] brpt = '0;
  logic [7:0]  bus_data = '0;
  logic [12:0] rom_data = '0;
  logic [15:0] rom_addr, pc;
  logic [12:0] instr;
  logic        running, halted;

  logic [12:0] rom [0:65535];
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        rs;
    logic        st;
    logic [15:0] ps;
    logic        sl;
    logic [7:0]  bd;
    logic [15:0] bp;
    logic [12:0] ei;
    logic [15:0] ep;
    logic [15:0] ea;
    logic        er;
    logic        eh;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  oisc8_seq #(
    .PCWIDTH (16),
    .IWIDTH  (13),
    .RESET_PC(16'h0000)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .pc_start(pc_start),
    .stall   (stall),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .instr   (instr),
    .bus_data(bus_data),
    .brpt    (brpt),
    .pc      (pc),
    .running (running),
    .halted  (halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  function automatic logic [12:0] w(input logic [15:0] a);
    return {a[8], 4'h5, a[7:0]};
  endfunction

  function automatic vec_t mk(input logic rs, input logic st, input logic [15:0] ps,
                              input logic sl, input logic [7:0] bd, input logic [15:0] bp,
                              input logic [12:0] ei, input logic [15:0] ep,
                              input logic [15:0] ea, input logic er, input logic eh);
    vec_t v;
    v.rs = rs; v.st = st; v.ps = ps; v.sl = sl; v.bd = bd; v.bp = bp;
    v.ei = ei; v.ep = ep; v.ea = ea; v.er = er; v.eh = eh;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input int idx);
    vec_t e;
    @(posedge clk);
    #1;
    start    = v.st;
    pc_start = v.ps;
    stall    = v.sl;
    bus_data = v.bd;
    brpt     = v.bp;
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    chk($sformatf("instr[%0d]", idx), {3'b0, instr}, {3'b0, e.ei});
    chk($sformatf("pc[%0d]", idx), pc, e.ep);
    chk($sformatf("rom_addr[%0d]", idx), rom_addr, e.ea);
    chk($sformatf("running[%0d]", idx), {15'b0, running}, {15'b0, e.er});
    chk($sformatf("halted[%0d]", idx), {15'b0, halted}, {15'b0, e.eh});
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_instr"}, {3'b0, instr}, {3'b0, NOP});
    chk({tag, "_pc"}, pc, 16'h0000);
    chk({tag, "_rom_addr"}, rom_addr, 16'h0000);
    chk({tag, "_running"}, {15'b0, running}, 16'h0000);
    chk({tag, "_halted"}, {15'b0, halted}, 16'h0000);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst   = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    #1;
    reset_checks("reset");
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 65536; a++) rom[a] = w(16'(a));
    rom[16'h0020] = BRZI;
    rom[16'h0033] = BRZI;
    rom[16'h0040] = HLT;
    rom[16'h0050] = BRZB;
    rom[16'h0052] = BRZB;

    // sequential fetch from 0x10
    vecs.push_back(mk(1, 1, 16'h0010, 0, 8'h00, 16'hDEAD, NOP, 16'h0000, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 8'h00, 16'hDEAD, NOP, 16'h0000, 16'h0010, 1, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 8'h00, 16'hDEAD, w(16'h0010), 16'h0010, 16'h0011, 1, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 8'h00, 16'hDEAD, w(16'h0011), 16'h0011, 16'h0012, 1, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 8'h00, 16'hDEAD, w(16'h0012), 16'h0012, 16'h0013, 1, 0));
    // BRZ immediate taken (bus_data nonzero must not matter)
    vecs.push_back(mk(1, 1, 16'h0020, 0, 8'h00, 16'hDEAD, NOP, 16'h0000, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 8'h00, 16'hDEAD, NOP, 16'h0000, 16'h0020, 1, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 8'h77, 16'h0100, BRZI, 16'h0020, 16'h0021, 1, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 8'h00, 16'h0100, NOP, 16'h0020, 16'h0100, 1, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 8'h00, 16'hDEAD, w(16'h0100), 16'h0100, 16'h0101, 1, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 8'h00, 16'hDEAD, w(16'h0101), 16'h0101, 16'h0102, 1, 0));
    // BRZ on bus value: not taken with 0x05, taken with 0x00
    vecs.push_back(mk(1, 1, 16'h0050, 0, 8'h00, 16'hDEAD, NOP, 16'h0000, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 8'h00, 16'hDEAD, NOP, 16'h0000, 16'h0050, 1, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 8'h05, 16'h0200, BRZB, 16'h0050, 16'h0051, 1, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 8'h00, 16'h0200, w(16'h0051), 16'h0051, 16'h0052, 1, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 8'h00, 16'h0200, BRZB, 16'h0052, 16'h0053, 1, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 8'h00, 16'hDEAD, NOP, 16'h0052, 16'h0200, 1, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 8'h00, 16'hDEAD, w(16'h0200), 16'h0200, 16'h0201, 1, 0));
    // 3-cycle stall at 0x30, then stall on a BRZ at 0x33, stall ignored in FLUSH
    vecs.push_back(mk(1, 1, 16'h0030, 0, 8'h00, 16'hDEAD, NOP, 16'h0000, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 8'h00, 16'hDEAD, NOP, 16'h0000, 16'h0030, 1, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 8'h00, 16'hDEAD, NOP, 16'h0030, 16'h0031, 1, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 8'h00, 16'hDEAD, NOP, 16'h0030, 16'h0031, 1, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 8'h00, 16'hDEAD, NOP, 16'h0030, 16'h0031, 1, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 8'h00, 16'hDEAD, w(16'h0030), 16'h0030, 16'h0031, 1, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 8'h00, 16'hDEAD, w(16'h0031), 16'h0031, 16'h0032, 1, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 8'h00, 16'hDEAD, w(16'h0032), 16'h0032, 16'h0033, 1, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 8'h00, 16'h0300, NOP, 16'h0033, 16'h0034, 1, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 8'h00, 16'h0300, BRZI, 16'h0033, 16'h0034, 1, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 8'h00, 16'hDEAD, NOP, 16'h0033, 16'h0300, 1, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 8'h00, 16'hDEAD, w(16'h0300), 16'h0300, 16'h0301, 1, 0));
    // HALT at 0x40, restart at 0, start while running ignored
    vecs.push_back(mk(1, 1, 16'h0040, 0, 8'h00, 16'hDEAD, NOP, 16'h0000, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 8'h00, 16'hDEAD, NOP, 16'h0000, 16'h0040, 1, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 8'h00, 16'hDEAD, HLT, 16'h0040, 16'h0041, 1, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 8'h00, 16'hDEAD, NOP, 16'h0040, 16'h0041, 0, 1));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 8'h00, 16'hDEAD, NOP, 16'h0040, 16'h0041, 0, 1));
    vecs.push_back(mk(0, 1, 16'h0000, 0, 8'h00, 16'hDEAD, NOP, 16'h0040, 16'h0041, 0, 1));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 8'h00, 16'hDEAD, NOP, 16'h0040, 16'h0000, 1, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 8'h00, 16'hDEAD, w(16'h0000), 16'h0000, 16'h0001, 1, 0));
    vecs.push_back(mk(0, 1, 16'h0040, 0, 8'h00, 16'hDEAD, w(16'h0001), 16'h0001, 16'h0002, 1, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 8'h00, 16'hDEAD, w(16'h0002), 16'h0002, 16'h0003, 1, 0));

    foreach (vecs[i]) begin
      if (vecs[i].rs) do_reset();
      step(vecs[i], i);
    end

    // reset asserted in STALL at 0x7FFF while stall drops: skid word must not appear
    do_reset();
    step(mk(0, 1, 16'h7FFF, 0, 8'h00, 16'hDEAD, NOP, 16'h0000, 16'h0000, 0, 0), 100);
    step(mk(0, 0, 16'h0000, 0, 8'h00, 16'hDEAD, NOP, 16'h0000, 16'h7FFF, 1, 0), 101);
    step(mk(0, 0, 16'h0000, 1, 8'h00, 16'hDEAD, NOP, 16'h7FFF, 16'h8000, 1, 0), 102);
    @(posedge clk);
    #1;
    stall = 1'b0;
    rst   = 1'b1;
    #1;
    reset_checks("rst_in_stall");
    @(negedge clk);
    #1 rst = 1'b0;
    step(mk(0, 0, 16'h0000, 0, 8'h00, 16'hDEAD, NOP, 16'h0000, 16'h0000, 0, 0), 103);

    // sequential wrap through 0xFFFF
    do_reset();
    step(mk(0, 1, 16'hFFFE, 0, 8'h00, 16'hDEAD, NOP, 16'h0000, 16'h0000, 0, 0), 200);
    step(mk(0, 0, 16'h0000, 0, 8'h00, 16'hDEAD, NOP, 16'h0000, 16'hFFFE, 1, 0), 201);
    step(mk(0, 0, 16'h0000, 0, 8'h00, 16'hDEAD, w(16'hFFFE), 16'hFFFE, 16'hFFFF, 1, 0), 202);
    step(mk(0, 0, 16'h0000, 0, 8'h00, 16'hDEAD, w(16'hFFFF), 16'hFFFF, 16'h0000, 1, 0), 203);
    step(mk(0, 0, 16'h0000, 0, 8'h00, 16'hDEAD, w(16'h0000), 16'h0000, 16'h0001, 1, 0), 204);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
